// File: rtl/leaf_pkt_pkg.sv
// BFT packet layout shared by the leaf transmit and receive interfaces.
package leaf_pkt_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int DEST_BITS             = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CREDIT_MAX            = 2**NUM_ADDR_BITS;
  localparam int CREDIT_BITS           = NUM_ADDR_BITS + 1;

  localparam int VALID_BIT = PACKET_BITS - 1;
  localparam int LEAF_LSB  = VALID_BIT - NUM_LEAF_BITS;
  localparam int PORT_LSB  = LEAF_LSB - NUM_PORT_BITS;
  localparam int ADDR_LSB  = PORT_LSB - NUM_ADDR_BITS;

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  function automatic logic [PACKET_BITS-1:0] pack_pkt(input pkt_t p);
    return p;
  endfunction

  function automatic pkt_t unpack_pkt(input logic [PACKET_BITS-1:0] raw);
    return pkt_t'(raw);
  endfunction

  // Port named by a credit-return packet; 0 (never a real port) when not valid.
  function automatic logic [NUM_PORT_BITS-1:0] credit_port(input logic [PACKET_BITS-1:0] raw);
    pkt_t p;
    p = unpack_pkt(raw);
    return p.vld ? p.port : '0;
  endfunction

endpackage

// File: rtl/leaf_tx_packetizer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the port after the last grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;
  logic          found;

  always_comb begin
    int idx;
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        last_d     = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Reset points at the highest port so the first search starts at port index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PW'(N - 1);
    end else if (advance && found) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Leaf transmit packetizer: arbitrates user output streams into BFT packets
// with per-port routing, write-address sequencing, credits and resend hold.
module leaf_tx_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 3
) (
  input  logic                                  clk,
  input  logic                                  ap_rst_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_wr_en,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port_sel,
  input  logic [DEST_BITS-1:0]                  cfg_dest,
  input  logic [PACKET_BITS-1:0]                din_credit,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  output logic                                  credit_err
);

  logic [NUM_OUT_PORTS-1:0]                    req, grant, ovf;
  logic [NUM_OUT_PORTS-1:0][DEST_BITS-1:0]     port_dest;
  logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] port_addr;
  logic [NUM_PORT_BITS-1:0]                    cred_port;
  logic [PACKET_BITS-1:0]                      dout_q, dout_d;
  logic                                        credit_err_q, credit_err_d;

  assign cred_port = credit_port(din_credit);

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_port
    localparam logic [NUM_PORT_BITS-1:0] PORT_ID = NUM_PORT_BITS'(k + 1);

    logic [DEST_BITS-1:0]     dest_q, dest_d;
    logic                     dest_vld_q, dest_vld_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CREDIT_BITS-1:0]   credit_q, credit_d;
    logic [CREDIT_BITS:0]     credit_sum;
    logic                     cfg_hit, cred_hit, ovf_k;

    always_comb begin
      cfg_hit    = cfg_wr_en && (cfg_port_sel == PORT_ID);
      cred_hit   = (cred_port == PORT_ID);
      credit_sum = {1'b0, credit_q}
                 + (cred_hit ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0)
                 - {{CREDIT_BITS{1'b0}}, grant[k]};
      dest_d     = dest_q;
      dest_vld_d = dest_vld_q;
      addr_d     = addr_q;
      ovf_k      = 1'b0;
      if (credit_sum > (CREDIT_BITS+1)'(CREDIT_MAX)) begin
        credit_d = CREDIT_BITS'(CREDIT_MAX);
        ovf_k    = 1'b1;
      end else begin
        credit_d = credit_sum[CREDIT_BITS-1:0];
      end
      if (grant[k]) addr_d = addr_q + NUM_ADDR_BITS'(1);
      // A config write restarts the stream toward the new destination.
      if (cfg_hit) begin
        dest_d     = cfg_dest;
        dest_vld_d = 1'b1;
        addr_d     = '0;
        credit_d   = CREDIT_BITS'(CREDIT_MAX);
      end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        dest_q     <= '0;
        dest_vld_q <= 1'b0;
        addr_q     <= '0;
        credit_q   <= CREDIT_BITS'(CREDIT_MAX);
      end else begin
        dest_q     <= dest_d;
        dest_vld_q <= dest_vld_d;
        addr_q     <= addr_d;
        credit_q   <= credit_d;
      end
    end

    assign req[k]       = vld_user2interface[k] & dest_vld_q & (credit_q != '0) & ~resend;
    assign ovf[k]       = ovf_k;
    assign port_dest[k] = dest_q;
    assign port_addr[k] = addr_q;
  end

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (ap_rst_n),
    .req     (req),
    .advance (~resend),
    .grant   (grant)
  );

  always_comb begin
    pkt_t sel;
    sel = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (grant[k]) begin
        sel.vld     = 1'b1;
        sel.leaf    = port_dest[k][DEST_BITS-1:NUM_PORT_BITS];
        sel.port    = port_dest[k][NUM_PORT_BITS-1:0];
        sel.addr    = port_addr[k];
        sel.payload = din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
    dout_d       = resend ? dout_q : pack_pkt(sel);
    credit_err_d = credit_err_q | (|ovf);
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q       <= '0;
      credit_err_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = dout_q;
  assign credit_err              = credit_err_q;

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// Scoreboard bench for leaf_tx_packetizer: directed stimulus pushes expected
// packets, a negedge monitor pops and compares whatever appears on dout.
module tb_leaf_tx_packetizer;

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic [95:0] din;
  logic [2:0]  vld;
  logic [2:0]  ack;
  logic        cfg_wr_en;
  logic [3:0]  cfg_port_sel;
  logic [8:0]  cfg_dest;
  logic [48:0] din_credit;
  logic        resend;
  logic [48:0] dout;
  logic        credit_err;

  always #5 clk = ~clk;

  leaf_tx_packetizer #(.NUM_OUT_PORTS(3)) dut (
    .clk                     (clk),
    .ap_rst_n                (ap_rst_n),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr_en               (cfg_wr_en),
    .cfg_port_sel            (cfg_port_sel),
    .cfg_dest                (cfg_dest),
    .din_credit              (din_credit),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout),
    .credit_err              (credit_err)
  );

  logic [48:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  dest_m[1:3];
  logic [6:0]  addr_m[1:3];
  logic [31:0] w[1:3];
  logic [48:0] last_pkt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (ap_rst_n === 1'b1 && dout[48] === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_pkt", 64'(dout), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("dout_pkt", 64'(dout), 64'(e));
        end
      end
    end
  end

  // One cycle: drive inputs, check acks mid-cycle, record the packets they imply.
  task automatic step(input logic [2:0] v, input logic [2:0] eack,
                      input logic rs = 1'b0, input logic [3:0] cp = 4'd0);
    vld        = v;
    resend     = rs;
    din_credit = (cp != 4'd0) ? {1'b1, 5'd0, cp, 7'd0, 32'd0} : 49'd0;
    din        = {w[3], w[2], w[1]};
    @(negedge clk);
    chk("ack", 64'(ack), 64'(eack));
    if (rs) exp_q.push_back(last_pkt);
    for (int p = 1; p <= 3; p++) begin
      if (eack[p-1]) begin
        last_pkt = {1'b1, dest_m[p], addr_m[p], w[p]};
        exp_q.push_back(last_pkt);
        addr_m[p] = addr_m[p] + 7'd1;
        w[p]      = w[p] + 32'h0101_0101;
      end
    end
    @(posedge clk);
    #1;
    vld        = 3'b000;
    resend     = 1'b0;
    din_credit = '0;
  endtask

  task automatic cfg(input int p, input logic [4:0] leaf, input logic [3:0] dp);
    cfg_wr_en    = 1'b1;
    cfg_port_sel = 4'(p);
    cfg_dest     = {leaf, dp};
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
    if (p >= 1 && p <= 3) begin
      dest_m[p] = {leaf, dp};
      addr_m[p] = 7'd0;
    end
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    ap_rst_n     = 1'b0;
    vld          = 3'b111;
    din          = '0;
    cfg_wr_en    = 1'b0;
    cfg_port_sel = '0;
    cfg_dest     = '0;
    din_credit   = '0;
    resend       = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      dest_m[p] = '0;
      addr_m[p] = '0;
      w[p]      = 32'h1000_0000 * p;
    end

    @(negedge clk);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_credit_err", 64'(credit_err), 64'd0);
    @(posedge clk);
    #1;
    ap_rst_n = 1'b1;
    vld      = 3'b000;

    // No destinations configured; out-of-range selects must not enable a port.
    step(3'b111, 3'b000);
    cfg(0, 5'd1, 4'd1);
    cfg(4, 5'd1, 4'd1);
    step(3'b111, 3'b000);

    // Single word
    cfg(1, 5'd3, 4'd2);
    w[1] = 32'hDEAD_BEEF;
    step(3'b001, 3'b001);
    chk("single_word_exact", 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEAD_BEEF}), 64'(last_pkt));
    step(3'b000, 3'b000);

    // Fairness: pointer sits on port 1 after the single word.
    cfg(2, 5'd4, 4'd1);
    cfg(3, 5'd7, 4'd9);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b000, 3'b000);

    // Credit exhaustion on port 2, addresses wrap 127 -> 0.
    cfg(2, 5'd4, 4'd1);
    for (int i = 0; i < 128; i++) step(3'b010, 3'b010);
    step(3'b010, 3'b000);
    step(3'b010, 3'b000);
    step(3'b010, 3'b000, 1'b0, 4'd2);
    for (int i = 0; i < 64; i++) step(3'b010, 3'b010);
    step(3'b010, 3'b000);

    // Resend: port 3 addr 5 held for two extra cycles, then addr 6.
    step(3'b100, 3'b100);
    step(3'b100, 3'b100);
    step(3'b100, 3'b100);
    step(3'b100, 3'b100);
    chk("resend_addr5", 64'(last_pkt[38:32]), 64'd5);
    step(3'b100, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    step(3'b100, 3'b100);
    chk("after_resend_addr6", 64'(last_pkt[38:32]), 64'd6);
    step(3'b000, 3'b000);
    chk("credit_err_clean", 64'(credit_err), 64'd0);

    // Simultaneous credit return and grant at credit 10 -> 73.
    cfg(1, 5'd3, 4'd2);
    for (int i = 0; i < 118; i++) step(3'b001, 3'b001);
    step(3'b001, 3'b001, 1'b0, 4'd1);
    for (int i = 0; i < 73; i++) step(3'b001, 3'b001);
    step(3'b001, 3'b000);
    chk("credit_err_after_73", 64'(credit_err), 64'd0);
    step(3'b000, 3'b000, 1'b0, 4'd1);
    step(3'b000, 3'b000, 1'b0, 4'd1);
    chk("credit_err_at_128", 64'(credit_err), 64'd0);
    for (int i = 0; i < 28; i++) step(3'b001, 3'b001);
    step(3'b000, 3'b000, 1'b0, 4'd1);
    chk("credit_err_overflow", 64'(credit_err), 64'd1);
    for (int i = 0; i < 128; i++) step(3'b001, 3'b001);
    step(3'b001, 3'b000);
    chk("credit_err_sticky", 64'(credit_err), 64'd1);

    // Async reset mid-stream: only port 3 still holds credit.
    step(3'b111, 3'b100);
    #2;
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_dout", 64'(dout), 64'd0);
    vld = 3'b111;
    #1;
    chk("async_reset_ack", 64'(ack), 64'd0);
    chk("async_reset_credit_err", 64'(credit_err), 64'd0);
    @(posedge clk);
    #1;
    ap_rst_n = 1'b1;
    vld      = 3'b000;
    step(3'b111, 3'b000);
    step(3'b000, 3'b000, 1'b0, 4'd2);
    chk("reset_credit_full", 64'(credit_err), 64'd1);
    cfg(1, 5'd9, 4'd3);
    cfg(2, 5'd10, 4'd4);
    cfg(3, 5'd11, 4'd5);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
